mem_port_pipe_ctrl: RTL and testbench

//  Next-generation memory-model port controller. Bridges one core-side cmd/r/w handshake port to a

---
 rtl/mem_port_pipe_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_pipe_ctrl.sv
// Memory-model port controller: one core-side cmd/r/w handshake port bridged to a
// word-addressed array with async read and sync write. Reads go through a
// fixed-latency pipeline and a response FIFO so several can be outstanding.
module mem_port_pipe_ctrl #(
    parameter int unsigned p_ADDR_BITS  = 32,
    parameter int unsigned p_DATA_BITS  = 32,
    parameter int unsigned p_STRB_BITS  = p_DATA_BITS / 8,
    parameter int unsigned p_RD_LATENCY = 2,
    parameter int unsigned p_RSP_DEPTH  = 4,
    parameter int unsigned p_MEM_BYTES  = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [p_ADDR_BITS-1:0] mem_addr,
    input  logic                   mem_cmd,
    input  logic [1:0]             mem_size,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic                   mem_r_ready,
    output logic                   mem_r_valid,
    output logic [p_DATA_BITS-1:0] mem_r_data,
    output logic                   mem_r_resp,
    input  logic                   mem_w_valid,
    output logic                   mem_w_ready,
    input  logic [p_STRB_BITS-1:0] mem_w_strb,
    input  logic [p_DATA_BITS-1:0] mem_w_data,
    output logic                   mem_w_done,
    output logic                   mem_w_resp,
    output logic [p_ADDR_BITS-1:0] addr,
    output logic                   rden,
    input  logic [p_DATA_BITS-1:0] rddata,
    output logic                   wren,
    output logic [p_STRB_BITS-1:0] wrstrb,
    output logic [p_DATA_BITS-1:0] wrdata
);

    localparam int unsigned CNT_W = $clog2(p_RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(p_RSP_DEPTH);
    localparam int unsigned LAT   = p_RD_LATENCY;
    localparam logic [p_ADDR_BITS:0] MEM_LIMIT = (p_ADDR_BITS + 1)'(p_MEM_BYTES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_RSP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_BUSY = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] out_cnt_nxt;

    logic             err;
    logic             rd_acc;
    logic             wr_acc;
    logic             pop;
    logic             fifo_push;
    logic             fifo_pop;

    logic                   pipe_vld  [LAT];
    logic [p_DATA_BITS-1:0] pipe_data [LAT];
    logic                   pipe_err  [LAT];

    logic [p_DATA_BITS-1:0] fifo_data [p_RSP_DEPTH];
    logic                   fifo_err  [p_RSP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_empty;

    // Size/alignment/range error classification of the current command
    always_comb begin
        err = ({1'b0, mem_addr} >= MEM_LIMIT);
        unique case (mem_size)
            2'd0:    err = err;
            2'd1:    err = err | mem_addr[0];
            2'd2:    err = err | (|mem_addr[1:0]);
            default: err = 1'b1;
        endcase
    end

    // Response head: FIFO entry if any, else the entry leaving the pipeline this cycle
    always_comb begin
        fifo_empty  = (fifo_cnt == '0);
        mem_r_valid = !fifo_empty | pipe_vld[LAT-1];
        mem_r_data  = fifo_empty ? pipe_data[LAT-1] : fifo_data[rd_ptr];
        mem_r_resp  = fifo_empty ? pipe_err[LAT-1]  : fifo_err[rd_ptr];
        pop         = mem_r_valid & mem_r_ready;
        fifo_pop    = pop & !fifo_empty;
        fifo_push   = pipe_vld[LAT-1] & !(fifo_empty & pop);
    end

    // Mode state and outstanding-read counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

    // Accept decisions, array strobes and next mode
    always_comb begin
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;
        mem_ready   = 1'b0;
        mem_w_ready = 1'b0;
        rden        = 1'b0;
        wren        = 1'b0;
        addr        = '0;
        wrstrb      = '0;
        wrdata      = '0;
        state_nxt   = state;
        if (!rst) begin
            rd_acc      = mem_valid & !mem_cmd & (state != S_FULL);
            wr_acc      = mem_valid & mem_cmd & mem_w_valid & (state == S_IDLE);
            mem_ready   = rd_acc | wr_acc;
            mem_w_ready = wr_acc;
            rden        = rd_acc & !err;
            wren        = wr_acc & !err;
            addr        = {mem_addr[p_ADDR_BITS-1:2], 2'b00};
            wrstrb      = mem_w_strb;
            wrdata      = mem_w_data;
        end
        out_cnt_nxt = out_cnt + CNT_W'(rd_acc) - CNT_W'(pop);
        if (out_cnt_nxt == '0) begin
            state_nxt = S_IDLE;
        end else if (out_cnt_nxt == CNT_FULL) begin
            state_nxt = S_FULL;
        end else begin
            state_nxt = S_RD_BUSY;
        end
    end

    // Read latency pipeline; array data is captured in the accept cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= '0;
                pipe_err[i]  <= 1'b0;
            end
        end else begin
            pipe_vld[0]  <= rd_acc;
            pipe_data[0] <= err ? '0 : rddata;
            pipe_err[0]  <= err;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_err[i]  <= pipe_err[i-1];
            end
        end
    end

    // Response FIFO; the outstanding limit guarantees it never overflows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < p_RSP_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_err[i]  <= 1'b0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_data[wr_ptr] <= pipe_data[LAT-1];
                fifo_err[wr_ptr]  <= pipe_err[LAT-1];
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    // Write-done pulse with error flag, one cycle after write accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_w_done <= 1'b0;
            mem_w_resp <= 1'b0;
        end else begin
            mem_w_done <= wr_acc;
            mem_w_resp <= wr_acc & err;
        end
    end

endmodule

// File: tb/tb_mem_port_pipe_ctrl.sv
// Bench for mem_port_pipe_ctrl: directed scenarios plus random traffic, checked
// against a byte-level memory model and an in-order expected-response queue.
module tb_mem_port_pipe_ctrl;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MEMB  = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_cmd;
    logic [1:0]  mem_size;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_r_ready;
    logic        mem_r_valid;
    logic [31:0] mem_r_data;
    logic        mem_r_resp;
    logic        mem_w_valid;
    logic        mem_w_ready;
    logic [3:0]  mem_w_strb;
    logic [31:0] mem_w_data;
    logic        mem_w_done;
    logic        mem_w_resp;
    logic [31:0] addr;
    logic        rden;
    logic [31:0] rddata;
    logic        wren;
    logic [3:0]  wrstrb;
    logic [31:0] wrdata;

    mem_port_pipe_ctrl #(
        .p_ADDR_BITS (32),
        .p_DATA_BITS (32),
        .p_STRB_BITS (4),
        .p_RD_LATENCY(LAT),
        .p_RSP_DEPTH (DEPTH),
        .p_MEM_BYTES (MEMB)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_r_ready(mem_r_ready), .mem_r_valid(mem_r_valid),
        .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data),
        .mem_w_done(mem_w_done), .mem_w_resp(mem_w_resp),
        .addr(addr), .rden(rden), .rddata(rddata),
        .wren(wren), .wrstrb(wrstrb), .wrdata(wrdata)
    );

    always #5 clk = ~clk;

    // Array attached to the controller (async read, sync byte-strobed write)
    logic [31:0] arr [16384];
    assign rddata = arr[addr[15:2]];
    always @(posedge clk) begin
        if (wren) begin
            for (int i = 0; i < 4; i++) begin
                if (wrstrb[i]) arr[addr[15:2]][8*i +: 8] = wrdata[8*i +: 8];
            end
        end
    end

    // Reference model state
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    bit [7:0] ref_b [MEMB];
    rsp_t     exp_q [$];
    logic     exp_done;
    logic     exp_wresp;
    int       cyc;
    int       n_cmp;
    int       n_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= MEMB) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a) & ~3;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        int b;
        b = int'(a) & ~3;
        arr[b/4] = v;
        for (int i = 0; i < 4; i++) ref_b[b+i] = v[8*i +: 8];
    endtask

    // Cycle-level checker: handshakes, array strobes, response order/latency/data, write done
    always @(negedge clk) begin
        logic e, rd_ok, wr_ok, head_vis;
        int   base;
        if (rst) begin
            exp_q.delete();
            exp_done = 1'b0;
            chk("rst_ready", 32'(mem_ready), 32'd0);
            chk("rst_r_valid", 32'(mem_r_valid), 32'd0);
            chk("rst_w_done", 32'(mem_w_done), 32'd0);
            chk("rst_wren", 32'(wren), 32'd0);
        end else begin
            chk("w_done", 32'(mem_w_done), 32'(exp_done));
            if (exp_done) chk("w_resp", 32'(mem_w_resp), 32'(exp_wresp));
            exp_done = 1'b0;

            e     = model_err(mem_size, mem_addr);
            rd_ok = mem_valid && !mem_cmd && (exp_q.size() < DEPTH);
            wr_ok = mem_valid && mem_cmd && mem_w_valid && (exp_q.size() == 0);
            chk("mem_ready", 32'(mem_ready), 32'(rd_ok || wr_ok));
            chk("w_ready", 32'(mem_w_ready), 32'(wr_ok));
            chk("rden", 32'(rden), 32'(rd_ok && !e));
            chk("wren", 32'(wren), 32'(wr_ok && !e));
            if (rd_ok || wr_ok) chk("addr", addr, mem_addr & ~32'd3);

            head_vis = (exp_q.size() > 0) && (exp_q[0].cyc + int'(LAT) <= cyc);
            chk("r_valid", 32'(mem_r_valid), 32'(head_vis));
            if (head_vis) begin
                chk("r_data", mem_r_data, exp_q[0].data);
                chk("r_resp", 32'(mem_r_resp), 32'(exp_q[0].err));
                if (mem_r_ready) void'(exp_q.pop_front());
            end

            if (rd_ok) exp_q.push_back('{cyc, e ? 32'd0 : ref_word(mem_addr), e});
            if (wr_ok) begin
                exp_done  = 1'b1;
                exp_wresp = e;
                if (!e) begin
                    chk("wrdata", wrdata, mem_w_data);
                    chk("wrstrb", 32'(wrstrb), 32'(mem_w_strb));
                    base = int'(mem_addr) & ~3;
                    for (int i = 0; i < 4; i++)
                        if (mem_w_strb[i]) ref_b[base+i] = mem_w_data[8*i +: 8];
                end
            end
        end
    end

    task automatic drive(input logic v, input logic c, input logic [1:0] sz,
                         input logic [31:0] a, input logic wv, input logic [3:0] st,
                         input logic [31:0] wd, input logic rr);
        @(posedge clk);
        #1;
        mem_valid   = v;
        mem_cmd     = c;
        mem_size    = sz;
        mem_addr    = a;
        mem_w_valid = wv;
        mem_w_strb  = st;
        mem_w_data  = wd;
        mem_r_ready = rr;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 4'h0, 32'd0, rr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        exp_done = 1'b0;
        exp_wresp = 1'b0;
        rst = 1'b1;
        mem_valid = 1'b0; mem_cmd = 1'b0; mem_size = 2'd2; mem_addr = 32'd0;
        mem_w_valid = 1'b0; mem_w_strb = 4'h0; mem_w_data = 32'd0; mem_r_ready = 1'b0;
        for (int i = 0; i < 16384; i++) set_word(32'(i * 4), $urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Word read with latency LAT
        set_word(32'h10, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 2'd2, 32'h10, 1'b0, 4'h0, 32'd0, 1'b1);
        idle(5, 1'b1);

        // Outstanding limit with response backpressure
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 2'd2, 32'(32'h40 + 4 * i), 1'b0, 4'h0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 2'd2, 32'h80, 1'b0, 4'h0, 32'd0, 1'b1);
        idle(8, 1'b1);

        // Strobed write then read-back
        set_word(32'h20, 32'hAABBCCDD);
        drive(1'b1, 1'b1, 2'd2, 32'h20, 1'b1, 4'b0101, 32'h11223344, 1'b1);
        drive(1'b1, 1'b0, 2'd2, 32'h20, 1'b0, 4'h0, 32'd0, 1'b1);
        idle(4, 1'b1);

        // Error responses: misaligned half read, out-of-range write
        drive(1'b1, 1'b0, 2'd1, 32'h21, 1'b0, 4'h0, 32'd0, 1'b1);
        drive(1'b1, 1'b1, 2'd2, 32'h10002, 1'b1, 4'hF, 32'h55AA55AA, 1'b1);
        idle(4, 1'b1);

        // Write held off behind outstanding reads; command without data not accepted
        drive(1'b1, 1'b0, 2'd2, 32'h30, 1'b0, 4'h0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 2'd0, 32'h33, 1'b0, 4'h0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'd2, 32'h30, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0);
        drive(1'b1, 1'b1, 2'd2, 32'h30, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1);
        drive(1'b1, 1'b1, 2'd2, 32'h30, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1);
        drive(1'b1, 1'b1, 2'd2, 32'h30, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1);
        drive(1'b0, 1'b1, 2'd2, 32'h30, 1'b1, 4'hF, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 2'd2, 32'h30, 1'b0, 4'h0, 32'd0, 1'b1);
        idle(4, 1'b1);

        // Reset with reads in flight, then a normal read
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'd2, 32'(32'h50 + 4 * i), 1'b0, 4'h0, 32'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 32'h54, 1'b0, 4'h0, 32'd0, 1'b1);
        idle(4, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r, ra;
            logic [1:0]  sz;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            sz = (r < 6) ? 2'd2 : (r < 8) ? 2'd0 : (r < 9) ? 2'd1 : 2'd3;
            ra = $urandom_range(0, 19);
            a  = (ra == 0) ? 32'(32'h10000 + $urandom_range(0, 255)) :
                 (ra == 1) ? 32'hFFFFFFFC : 32'($urandom_range(0, 255));
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, sz, a,
                  $urandom_range(0, 3) != 0, 4'($urandom), $urandom,
                  $urandom_range(0, 9) < 7);
        end
        idle(12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
